// File: rtl/int_to_fp_pipe.sv
// Three-stage integer -> IEEE-style float converter with valid/ready flow control.
// Define ROUND_NEAREST_EN for round-to-nearest-even; otherwise the magnitude is truncated.
module int_to_fp_pipe #(
  parameter int INT_W  = 32,
  parameter int EXP_W  = 8,
  parameter int MAN_W  = 23,
  parameter int SIGNED = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [INT_W-1:0]       in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out_fp,
  output logic                   out_inexact
);

  localparam int BIAS = 2**(EXP_W-1) - 1;
  localparam int PW   = $clog2(INT_W);
  localparam int XW   = INT_W + MAN_W + 2;

  generate
    if (BIAS + INT_W > 2**EXP_W - 2) begin : g_bad_cfg
      $error("int_to_fp_pipe: exponent range too small for INT_W");
    end
  endgenerate

  logic [3:1] r_vld_pipe;
  logic       w_stall, w_adv;

  assign out_valid = r_vld_pipe[3];
  assign w_stall   = r_vld_pipe[3] & ~out_ready;
  assign in_ready  = ~w_stall;
  assign w_adv     = ~w_stall;

  // S1: sign / magnitude
  logic             w_s1_sign;
  logic [INT_W-1:0] w_s1_mag;
  logic             r_s1_sign;
  logic [INT_W-1:0] r_s1_mag;

  assign w_s1_sign = (SIGNED != 0) ? in_data[INT_W-1] : 1'b0;
  assign w_s1_mag  = w_s1_sign ? (~in_data + 1'b1) : in_data;

  // S2: leading-one detect and normalise so the MSB becomes the hidden bit
  logic [PW-1:0]    w_p;
  logic             w_nz;
  logic [INT_W-1:0] w_norm;
  logic             r_s2_sign, r_s2_nz;
  logic [PW-1:0]    r_s2_p;
  logic [INT_W-1:0] r_s2_norm;

  always_comb begin
    w_p  = '0;
    w_nz = |r_s1_mag;
    for (int i = 0; i < INT_W; i++)
      if (r_s1_mag[i]) w_p = PW'(i);
    w_norm = r_s1_mag << (PW'(INT_W-1) - w_p);
  end

  // S3: mantissa extract, rounding, exponent
  logic [XW-1:0]    w_ext;
  logic [MAN_W-1:0] w_mant;
  logic             w_g, w_r, w_s, w_inc, w_carry;
  logic [MAN_W:0]   w_rnd;
  logic [EXP_W-1:0] w_exp;
  logic [EXP_W+MAN_W:0] w_fp;
  logic             w_inexact;
  logic [EXP_W+MAN_W:0] r_fp;
  logic             r_inexact;

  // Zero padding below the integer keeps the slicing valid when INT_W-1 < MAN_W.
  assign w_ext  = {r_s2_norm, {(MAN_W+2){1'b0}}};
  assign w_mant = w_ext[INT_W+MAN_W -: MAN_W];
  assign w_g    = w_ext[INT_W];
  assign w_r    = w_ext[INT_W-1];
  assign w_s    = |w_ext[INT_W-2:0];

`ifdef ROUND_NEAREST_EN
  assign w_inc = w_g & (w_r | w_s | w_mant[0]);
`else
  assign w_inc = 1'b0;
`endif

  assign w_rnd     = {1'b0, w_mant} + (MAN_W+1)'(w_inc);
  assign w_carry   = w_rnd[MAN_W];
  assign w_exp     = EXP_W'(r_s2_p) + EXP_W'(BIAS) + EXP_W'(w_carry);
  assign w_fp      = r_s2_nz ? {r_s2_sign, w_exp, w_rnd[MAN_W-1:0]} : '0;
  assign w_inexact = r_s2_nz & (w_g | w_r | w_s);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_pipe <= '0;
      r_s1_sign  <= 1'b0;
      r_s1_mag   <= '0;
      r_s2_sign  <= 1'b0;
      r_s2_nz    <= 1'b0;
      r_s2_p     <= '0;
      r_s2_norm  <= '0;
      r_fp       <= '0;
      r_inexact  <= 1'b0;
    end else if (w_adv) begin
      r_vld_pipe <= {r_vld_pipe[2:1], in_valid};
      r_s1_sign  <= w_s1_sign;
      r_s1_mag   <= w_s1_mag;
      r_s2_sign  <= r_s1_sign & w_nz;
      r_s2_nz    <= w_nz;
      r_s2_p     <= w_p;
      r_s2_norm  <= w_norm;
      r_fp       <= w_fp;
      r_inexact  <= w_inexact;
    end
  end

  assign out_fp      = r_fp;
  assign out_inexact = r_inexact;

endmodule
